// File: rtl/mandel_pixel_scheduler.sv
// Dispatches raster Mandelbrot pixel jobs round-robin to NUM_ENGINES iteration engines
// and retires their iteration counts strictly in raster order through a valid/ready port.
module mandel_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int ITER_W      = 8
) (
  input  logic                          out_stream_aclk,
  input  logic                          periph_resetn,
  input  logic                          enable,
  output logic [NUM_ENGINES-1:0]        eng_req_valid,
  input  logic [NUM_ENGINES-1:0]        eng_req_ready,
  output logic [9:0]                    eng_x,
  output logic [8:0]                    eng_y,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [ITER_W-1:0]             pix_iter,
  output logic [9:0]                    pix_x,
  output logic [8:0]                    pix_y,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          err_sticky
);

  localparam int          PTR_W  = $clog2(NUM_ENGINES);
  localparam logic [9:0]  X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0]  Y_LAST = 9'(Y_SIZE - 1);

  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DRAIN} top_state_e;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_RUN, SLOT_DONE} slot_state_e;

  typedef struct packed {
    logic [9:0]        x;
    logic [8:0]        y;
    logic [ITER_W-1:0] iter;
  } slot_data_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENGINES - 1)) ? '0 : p + 1'b1;
  endfunction

  top_state_e             top_state;
  top_state_e             top_next;
  slot_state_e            slot_state [NUM_ENGINES];
  slot_data_t             slot_data  [NUM_ENGINES];
  logic [PTR_W-1:0]       dp;
  logic [PTR_W-1:0]       rp;
  logic [9:0]             gx;
  logic [8:0]             gy;

  logic [NUM_ENGINES-1:0] slot_free_vec;
  logic [NUM_ENGINES-1:0] slot_run_vec;
  logic [NUM_ENGINES-1:0] dispatch_sel;
  logic [NUM_ENGINES-1:0] retire_sel;
  logic                   dispatch_fire;
  logic                   retire_fire;
  logic                   last_job;
  logic                   all_free;

  // NOTE: defaults are assigned first so no path through a combinational block leaves a variable unassigned and infers a latch.
  always_comb begin
    slot_free_vec = '0;
    slot_run_vec  = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      slot_free_vec[k] = (slot_state[k] == SLOT_FREE);
      slot_run_vec[k]  = (slot_state[k] == SLOT_RUN);
    end
  end

  assign all_free      = &slot_free_vec;
  assign dispatch_sel  = eng_req_valid & eng_req_ready;
  assign dispatch_fire = |dispatch_sel;
  assign last_job      = (gx == X_LAST) && (gy == Y_LAST);

  // Retire side reads only registered slot state, so pix_valid has no path from any input.
  assign pix_valid   = (slot_state[rp] == SLOT_DONE);
  assign pix_x       = slot_data[rp].x;
  assign pix_y       = slot_data[rp].y;
  assign pix_iter    = slot_data[rp].iter;
  assign pix_sof     = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign pix_eol     = pix_valid && (pix_x == X_LAST);
  assign retire_fire = pix_valid && pix_ready;

  always_comb begin
    retire_sel     = '0;
    retire_sel[rp] = retire_fire;
  end

  assign eng_x = gx;
  assign eng_y = gy;

  // Top FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) top_state <= TOP_IDLE;
    else                top_state <= top_next;
  end

  // Top FSM: next-state logic. Dropping enable only takes effect at the frame boundary.
  always_comb begin
    top_next = top_state;
    unique case (top_state)
      TOP_IDLE:  if (enable) top_next = TOP_RUN;
      TOP_RUN:   if (dispatch_fire && last_job && !enable) top_next = TOP_DRAIN;
      TOP_DRAIN: if (all_free) top_next = TOP_IDLE;
      default:   top_next = TOP_IDLE;
    endcase
  end

  // Top FSM: outputs. Only the slot under dp is ever offered, so the offer is one-hot.
  always_comb begin
    eng_req_valid = '0;
    if (top_state == TOP_RUN && slot_state[dp] == SLOT_FREE) eng_req_valid[dp] = 1'b1;
    busy = (top_state != TOP_IDLE) || !all_free;
  end

  // Job coordinate generator and round-robin pointers.
  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      gx <= '0;
      gy <= '0;
      dp <= '0;
      rp <= '0;
    end else begin
      if (top_state == TOP_IDLE && enable) begin
        gx <= '0;
        gy <= '0;
      end else if (dispatch_fire) begin
        dp <= ptr_inc(dp);
        if (gx == X_LAST) begin
          gx <= '0;
          gy <= (gy == Y_LAST) ? '0 : gy + 1'b1;
        end else begin
          gx <= gx + 1'b1;
        end
      end
      if (retire_fire) rp <= ptr_inc(rp);
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      frame_done <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      frame_done <= retire_fire && (pix_x == X_LAST) && (pix_y == Y_LAST);
      if (|(eng_done & ~slot_run_vec)) err_sticky <= 1'b1;
    end
  end

  // Per-slot lifecycle FREE -> RUN -> DONE -> FREE; each transition owns exactly one slot state.
  // NOTE: slot storage is reset because pix_* are read straight from it and must be 0 out of reset.
  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        slot_state[k] <= SLOT_FREE;
        slot_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        unique case (slot_state[k])
          SLOT_FREE: if (dispatch_sel[k]) begin
            slot_state[k]  <= SLOT_RUN;
            slot_data[k].x <= gx;
            slot_data[k].y <= gy;
          end
          SLOT_RUN: if (eng_done[k]) begin
            slot_state[k]     <= SLOT_DONE;
            slot_data[k].iter <= eng_iter[k*ITER_W +: ITER_W];
          end
          SLOT_DONE: if (retire_sel[k]) slot_state[k] <= SLOT_FREE;
          default:   slot_state[k] <= SLOT_FREE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler: engine models plus an in-order scoreboard
// fed at dispatch time and drained at pixel handshake, on a reduced 8x4 frame.
module tb_mandel_pixel_scheduler;

  localparam int NE    = 4;
  localparam int XS    = 8;
  localparam int YS    = 4;
  localparam int IW    = 8;
  localparam int FRAME = XS * YS;

  logic             clk = 1'b0;
  logic             periph_resetn;
  logic             enable;
  logic [NE-1:0]    eng_req_valid;
  logic [NE-1:0]    eng_req_ready;
  logic [9:0]       eng_x;
  logic [8:0]       eng_y;
  logic [NE-1:0]    eng_done;
  logic [NE*IW-1:0] eng_iter;
  logic             pix_valid;
  logic             pix_ready;
  logic [IW-1:0]    pix_iter;
  logic [9:0]       pix_x;
  logic [8:0]       pix_y;
  logic             pix_sof;
  logic             pix_eol;
  logic             frame_done;
  logic             busy;
  logic             err_sticky;
  logic [NE-1:0]    inj_done;

  always #5 clk = ~clk;

  mandel_pixel_scheduler #(
    .NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)
  ) dut (
    .out_stream_aclk(clk),
    .periph_resetn  (periph_resetn),
    .enable         (enable),
    .eng_req_valid  (eng_req_valid),
    .eng_req_ready  (eng_req_ready),
    .eng_x          (eng_x),
    .eng_y          (eng_y),
    .eng_done       (eng_done),
    .eng_iter       (eng_iter),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_iter       (pix_iter),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_sof        (pix_sof),
    .pix_eol        (pix_eol),
    .frame_done     (frame_done),
    .busy           (busy),
    .err_sticky     (err_sticky)
  );

  typedef struct {
    int x;
    int y;
    int it;
  } pix_t;

  int       checks = 0;
  int       errors = 0;
  pix_t     exp_q[$];
  int       nx, ny, exp_dp;
  int       disp_count = 0;
  int       pix_count = 0;
  int       frame_cnt = 0;
  int       retired_since_reset = 0;
  bit       fd_exp, hold;
  logic [9:0]    h_x;
  logic [8:0]    h_y;
  logic [IW-1:0] h_it;
  int            delay    [NE];
  int            cnt      [NE];
  bit            eng_busy [NE];
  logic [IW-1:0] job_iter [NE];

  function automatic logic [IW-1:0] iter_fn(input int x, input int y);
    return IW'(x * 5 + y * 11 + 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin step(); n++; end
    check("frame_wait", frame_cnt >= target, 1);
  endtask

  task automatic wait_disp(input int target, input int budget);
    int n = 0;
    while (disp_count < target && n < budget) begin step(); n++; end
    check("disp_wait", disp_count >= target, 1);
  endtask

  task automatic wait_pix(input int target, input int budget);
    int n = 0;
    while (pix_count < target && n < budget) begin step(); n++; end
    check("pix_wait", pix_count >= target, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    check("idle_wait", busy, 0);
  endtask

  // Engine models and output monitor; decisions at negedge describe the coming posedge.
  always @(negedge clk) begin
    logic [NE-1:0] d;
    pix_t          e;
    d = '0;
    if (!periph_resetn) begin
      exp_q.delete();
      nx = 0; ny = 0; exp_dp = 0;
      fd_exp = 0; hold = 0;
      retired_since_reset = 0;
      for (int k = 0; k < NE; k++) begin eng_busy[k] = 0; cnt[k] = 0; end
    end else begin
      check("frame_done", frame_done, fd_exp);
      if (fd_exp) frame_cnt++;
      fd_exp = 0;
      check("offer_onehot", $countones(eng_req_valid) <= 1, 1);
      if (hold) begin
        check("hold_valid", pix_valid, 1);
        check("hold_x", pix_x, h_x);
        check("hold_y", pix_y, h_y);
        check("hold_iter", pix_iter, h_it);
      end
      hold = pix_valid && !pix_ready;
      h_x = pix_x; h_y = pix_y; h_it = pix_iter;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_iter", pix_iter, e.it);
          check("pix_sof", pix_sof, (e.x == 0 && e.y == 0));
          check("pix_eol", pix_eol, (e.x == XS - 1));
          fd_exp = (e.x == XS - 1) && (e.y == YS - 1);
        end
        pix_count++;
        retired_since_reset++;
      end
      for (int k = 0; k < NE; k++) begin
        if (eng_busy[k]) begin
          cnt[k]--;
          if (cnt[k] == 0) begin d[k] = 1'b1; eng_busy[k] = 0; end
        end
      end
      for (int k = 0; k < NE; k++) begin
        if (eng_req_valid[k] && eng_req_ready[k]) begin
          check("disp_slot", k, exp_dp);
          check("eng_x", eng_x, nx);
          check("eng_y", eng_y, ny);
          eng_busy[k] = 1;
          cnt[k]      = delay[k];
          job_iter[k] = iter_fn(int'(eng_x), int'(eng_y));
          e.x = nx; e.y = ny; e.it = int'(iter_fn(nx, ny));
          exp_q.push_back(e);
          check("outstanding", exp_q.size() <= NE, 1);
          exp_dp = (exp_dp + 1) % NE;
          if (nx == XS - 1) begin nx = 0; ny = (ny == YS - 1) ? 0 : ny + 1; end
          else nx++;
          disp_count++;
        end
      end
    end
    eng_done = d | inj_done;
    for (int k = 0; k < NE; k++) eng_iter[k*IW +: IW] = job_iter[k];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    periph_resetn = 0; enable = 0; pix_ready = 1; eng_req_ready = '0; inj_done = '0;
    for (int k = 0; k < NE; k++) begin delay[k] = 3; job_iter[k] = '0; end
    repeat (3) step();
    check("rst_offer", eng_req_valid, 0);
    check("rst_eng_x", eng_x, 0);
    check("rst_eng_y", eng_y, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_iter", pix_iter, 0);
    check("rst_sof", pix_sof, 0);
    check("rst_eol", pix_eol, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_sticky, 0);
    periph_resetn = 1;
    step();
    check("idle_busy", busy, 0);
    check("idle_offer", eng_req_valid, 0);

    // T6: stray completion on a FREE slot.
    inj_done = 4'b0100;
    step();
    inj_done = '0;
    repeat (2) step();
    check("err_set", err_sticky, 1);
    check("err_no_pix", pix_valid, 0);
    check("err_busy", busy, 0);

    // T1: offer latency and hold, then two back-to-back frames.
    enable = 1;
    step();
    check("first_offer", eng_req_valid, 4'b0001);
    check("first_x", eng_x, 0);
    check("first_y", eng_y, 0);
    repeat (3) step();
    check("offer_hold", eng_req_valid, 4'b0001);
    check("offer_hold_x", eng_x, 0);
    check("offer_hold_y", eng_y, 0);
    eng_req_ready = '1;
    wait_frames(2, 400);

    // T3: downstream stall mid-frame.
    wait_pix(2 * FRAME + 10, 200);
    pix_ready = 0;
    repeat (10) step();
    for (int i = 0; i < 40; i++) begin
      check("stall_no_offer", eng_req_valid, 0);
      check("stall_valid", pix_valid, 1);
      step();
    end
    pix_ready = 1;

    // T4: enable dropped mid-frame; frame completes and FSM returns to IDLE.
    wait_disp(2 * FRAME + 2 * XS + 3, 200);
    enable = 0;
    wait_frames(3, 400);
    wait_idle(100);
    check("t4_pix_count", pix_count, 3 * FRAME);
    check("t4_disp_count", disp_count, 3 * FRAME);
    repeat (5) step();
    check("t4_idle_offer", eng_req_valid, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_err_kept", err_sticky, 1);

    // T2: engines finish in reverse order; output stays raster.
    delay[0] = 10; delay[1] = 8; delay[2] = 6; delay[3] = 3;
    enable = 1;
    repeat (2) step();
    enable = 0;
    wait_frames(4, 800);
    wait_idle(100);
    check("t2_pix_count", pix_count, 4 * FRAME);

    // T5: reset with jobs in flight, then restart from (0,0).
    for (int k = 0; k < NE; k++) delay[k] = 6;
    enable = 1;
    wait_disp(4 * FRAME + 3, 100);
    check("t5_busy_before", busy, 1);
    periph_resetn = 0;
    step();
    check("t5_offer", eng_req_valid, 0);
    check("t5_eng_x", eng_x, 0);
    check("t5_eng_y", eng_y, 0);
    check("t5_pix_valid", pix_valid, 0);
    check("t5_pix_x", pix_x, 0);
    check("t5_pix_y", pix_y, 0);
    check("t5_pix_iter", pix_iter, 0);
    check("t5_sof", pix_sof, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_busy", busy, 0);
    check("t5_err", err_sticky, 0);
    periph_resetn = 1;
    step();
    check("t5_restart_offer", eng_req_valid, 4'b0001);
    check("t5_restart_x", eng_x, 0);
    check("t5_restart_y", eng_y, 0);
    repeat (3) step();
    enable = 0;
    wait_frames(5, 800);
    wait_idle(100);
    check("t5_frame_pixels", retired_since_reset, FRAME);
    check("t5_err_clear", err_sticky, 0);
    check("final_offer", eng_req_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
